instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Front-end stage that sits directly upstream of `control_unit`: owns the fetch program counter, drives word addresses into the synchronous `random_access_memory`, absorbs its one-cycle read latency, and buffers fetched words in a small prefetch queue. Instructions leave on a valid/ready handshake together with the address they were fetched from. A redirect input (branch or write to r15) flushes everything in flight and restarts fetch at a new address.

## Interface
Parameters:
- `DEPTH`, 4: prefetch queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0: word address fetched first after reset.

Ports:
- `clk`  input  1  the design's single clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `mem_a`  output  32  word address to RAM port `a`; combinational from `fetch_pc`.
- `mem_rw`  output  1  RAM write enable; tied 0.
- `mem_dout`  input  32  RAM read data; holds `mem[a]` one edge after `a` is sampled.
- `redirect`  input  1  flush and restart fetch.
- `redirect_pc`  input  32  restart word address; sampled when `redirect`=1.
- `instr_valid`  output  1  queue head is valid.
- `instr_ready`  input  1  consumer accepts head.
- `instr`  output  32  head instruction word.
- `instr_pc`  output  32  word address of `instr`.

## Operation
- State: `fetch_pc`[31:0], `req_q` (a read is in flight), `req_pc_q`[31:0], queue occupancy `count` (0..DEPTH).
- Issue condition, evaluated every cycle: `!redirect && (count + req_q) < DEPTH`. Pops in the same cycle are not credited. On issue: `req_q`<=1, `req_pc_q`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+1 (wraps 32'hFFFFFFFF -> 0). If not issuing: `req_q`<=0 and `fetch_pc` holds.
- Return: when `req_q`=1 and no redirect, push {`mem_dout`, `req_pc_q`} into the queue.
- Pop: `instr_valid && instr_ready`. Push and pop may occur in the same cycle; `count` is then unchanged.
- Redirect (priority over all other events): `count`<=0, `req_q`<=0 (the in-flight return is dropped), `fetch_pc`<=`redirect_pc`. No issue occurs that cycle. A coincident pop still counts as a completed handshake.
- Push while full is unreachable under the credit rule; the bench asserts it never happens.
- Reset: `fetch_pc`=`RESET_PC`, `req_q`=0, `req_pc_q`=0, `count`=0. Outputs during reset: `instr_valid`=0, `instr`=0, `instr_pc`=0, `mem_rw`=0, `mem_a`=`RESET_PC`. Asserting reset mid-operation discards all queued and in-flight data.

## Timing
- Queue outputs are registered; there is no bypass from `mem_dout` to `instr`.
- Latency: if issue happens at edge E0, the return is pushed at E1 and `instr_valid` rises after E1.
- After reset deassert or redirect: the first issue is at the next edge E1, and `instr_valid` rises after E2, i.e. 2 cycles.
- Throughput: 1 instruction/cycle while `instr_ready` stays 1.
- Stall behaviour: with `instr_ready` held 0, at most `DEPTH` words are held in the queue and in flight combined. `instr`/`instr_pc` stay stable while `instr_valid`=1 and `instr_ready`=0.

## Structure
- Shared package `limb_pkg`: `WORD_W`=32, `addr_t`/`word_t` typedefs, `RESET_PC` default, and a `fetch_entry_t` struct {`word_t instr`, `addr_t pc`}. `control_unit` reuses these.
- One sub-module, `fetch_buffer`: synchronous FIFO of `fetch_entry_t`, `DEPTH` entries, with push/pop/flush, `count`, and registered head. Read and write pointers wrap modulo `DEPTH`.
- The top level holds `fetch_pc`, the issue/credit logic and the return tracking.

## Test plan
- Reset release with RAM[0..5]=A0..A5 and `instr_ready`=1 -> `instr_valid` rises 2 cycles after release; the output sequence is A0..A5 with `instr_pc` 0..5, one per cycle.
- `instr_ready`=0 for 10 cycles -> `mem_a` stops advancing at 4 (4 = `count` + `req_q`). After `instr_ready`=1 the output continues 0,1,2,3,4,... with no gap or duplicate.
- Redirect to 0x100 while the queue holds 3 entries and one read is in flight -> no stale word appears; the next valid output has `instr_pc`=0x100 exactly 2 cycles later.
- Redirect coincident with a pop, and a second redirect on the next cycle to 0x200 -> only the 0x200 stream appears.
- `fetch_pc`=32'hFFFFFFFE (reached via redirect) -> `instr_pc` sequence FFFFFFFE, FFFFFFFF, 0, 1.
- Assert `rst` mid-stream while the queue is full -> `instr_valid` goes 0 immediately (asynchronously). Fetch restarts from `RESET_PC` after deassert.

Source files
------------

// File: rtl/limb_pkg.sv
// rtl/limb_pkg.sv - shared fetch/control types
// Word and address types plus the entry carried from fetch to control.
package limb_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [WORD_W-1:0] addr_t;

  localparam addr_t DEFAULT_RESET_PC = '0;

  typedef struct packed {
    word_t instr;
    addr_t pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - prefetch FIFO of fetch entries
// Head is read from storage registers; flush empties the queue without clearing storage.
module fetch_buffer
  import limb_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC, credit-based issue and return tracking
// Issues one RAM read per cycle while queue plus in-flight reads leave room.
module instruction_fetch_unit
  import limb_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter addr_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_a,
  output logic        mem_rw,
  input  logic [31:0] mem_dout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  addr_t         fetch_pc_q, fetch_pc_d;
  addr_t         req_pc_q, req_pc_d;
  logic          req_q, req_d;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] q_count;
  fetch_entry_t  head;
  fetch_entry_t  ret_entry;

  // Pops are deliberately not credited, so a full queue never sees a push.
  assign issue     = !redirect && (({1'b0, q_count} + {{CW{1'b0}}, req_q}) < DEPTH_W);
  assign push      = req_q && !redirect;
  assign pop       = instr_valid && instr_ready;
  assign ret_entry = '{instr: mem_dout, pc: req_pc_q};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    req_d      = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      req_d      = 1'b1;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(ret_entry),
    .pop_i      (pop),
    .flush_i    (redirect),
    .head_o     (head),
    .valid_o    (instr_valid),
    .count_o    (q_count)
  );

  assign mem_a    = fetch_pc_q;
  assign mem_rw   = 1'b0;
  assign instr    = head.instr;
  assign instr_pc = head.pc;
endmodule
